// File: rtl/pixel_frame_buffer_if.sv
// Pixel write / scan-out bundle between the pattern modifier, the frame buffer
// and the LED driver.
interface pixel_frame_buffer_if;
    logic       wr_en;
    logic [3:0] xin;
    logic [3:0] yin;
    logic [4:0] rgbin;
    logic       swap;
    logic       start;
    logic [3:0] xout;
    logic [3:0] yout;
    logic [4:0] rgbout;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       swap_pending;
    logic       frame_done;

    modport master (
        output wr_en, xin, yin, rgbin, swap, start, out_ready,
        input  xout, yout, rgbout, out_valid, busy, swap_pending, frame_done
    );

    modport slave (
        input  wr_en, xin, yin, rgbin, swap, start, out_ready,
        output xout, yout, rgbout, out_valid, busy, swap_pending, frame_done
    );
endinterface

// File: rtl/pixel_frame_buffer.sv
// Double-buffered 16x16 x 5-bit frame store: writes fill the back bank, the front
// bank is scanned out in LED-strip order; bank swaps happen only between frames.
module pixel_frame_buffer #(
    parameter bit SERPENTINE = 1'b1
) (
    input  logic                  fclock,
    input  logic                  init,
    pixel_frame_buffer_if.slave   pb
);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [4:0] rgb;
    } pix_t;

    state_t     state, state_nx;
    logic       front;
    logic       swap_pend;
    logic       addr_ok;
    logic [7:0] n;
    logic [7:0] raddr;
    pix_t       pix;
    logic       last;

    logic [4:0] bank0 [256];
    logic [4:0] bank1 [256];

    // Pixel index -> {y,x} memory address in strip order.
    function automatic logic [7:0] scan_addr(input logic [7:0] idx);
        logic [3:0] col;
        col = idx[3:0];
        if (SERPENTINE && idx[4])
            col = ~idx[3:0];
        return {idx[7:4], col};
    endfunction

    assign last = (n == 8'hFF);

    always_ff @(posedge fclock or posedge init) begin
        if (init) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pb.start) state_nx = FETCH;
            FETCH:   if (addr_ok) state_nx = PRESENT;
            PRESENT: if (pb.out_ready) state_nx = last ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Back bank is always !front; a same-cycle swap still sees the old front here.
    always_ff @(posedge fclock) begin
        if (pb.wr_en) begin
            if (front) bank0[{pb.yin, pb.xin}] <= pb.rgbin;
            else       bank1[{pb.yin, pb.xin}] <= pb.rgbin;
        end
    end

    always_ff @(posedge fclock or posedge init) begin
        if (init) begin
            front     <= 1'b0;
            swap_pend <= 1'b0;
            addr_ok   <= 1'b0;
            n         <= 8'd0;
            raddr     <= 8'd0;
            pix       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pb.swap)
                        front <= ~front;
                    if (pb.start) begin
                        n       <= 8'd0;
                        addr_ok <= 1'b0;
                    end
                end
                FETCH: begin
                    if (pb.swap)
                        swap_pend <= 1'b1;
                    // First fetch of a scan registers the read address from the
                    // (possibly just swapped) front bank before reading it.
                    if (!addr_ok) begin
                        raddr   <= scan_addr(n);
                        addr_ok <= 1'b1;
                    end else begin
                        pix.x   <= raddr[3:0];
                        pix.y   <= raddr[7:4];
                        pix.rgb <= front ? bank1[raddr] : bank0[raddr];
                    end
                end
                PRESENT: begin
                    if (pb.swap)
                        swap_pend <= 1'b1;
                    if (pb.out_ready && !last) begin
                        n     <= n + 8'd1;
                        raddr <= scan_addr(n + 8'd1);
                    end
                end
                DONE: begin
                    if (swap_pend || pb.swap)
                        front <= ~front;
                    swap_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign pb.xout         = pix.x;
    assign pb.yout         = pix.y;
    assign pb.rgbout       = pix.rgb;
    assign pb.out_valid    = (state == PRESENT);
    assign pb.busy         = (state != IDLE);
    assign pb.swap_pending = swap_pend;
    assign pb.frame_done   = (state == DONE);

endmodule
